// File: rtl/mul_norm_shift.sv
// Post-multiply normalizer: applies the leading-one position to a product mantissa over a 2-stage valid/ready pipeline.
// Define MUL_NORM_DENORM_EN for gradual underflow; left undefined, underflowing results are flushed to zero.
module mul_norm_shift #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [CNT_W-1:0]  i_pos_one,
  input  logic              i_zero_flag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_zero,
  output logic              o_underflow
);

  localparam logic [EXP_W-1:0]  EXP_ZERO  = {EXP_W{1'b0}};
  localparam logic [MANT_W-1:0] MANT_ZERO = {MANT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
`ifdef MUL_NORM_DENORM_EN
  localparam logic [EXP_W-1:0]  EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
`endif

  logic              dec_zero_case;
  logic [CNT_W-1:0]  dec_sh;
  logic [EXP_W-1:0]  dec_exp;
  logic [MANT_W-1:0] dec_mant;
  logic              dec_zero;
  logic              dec_uf;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
  logic [CNT_W-1:0]  s1_sh_q, s1_sh_d;
  logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
  logic              s1_zero_q, s1_zero_d;
  logic              s1_uf_q, s1_uf_d;

  logic              o_valid_q, o_valid_d;
  logic              o_sign_q, o_sign_d;
  logic [EXP_W-1:0]  o_exp_q, o_exp_d;
  logic [MANT_W-1:0] o_mant_q, o_mant_d;
  logic              o_zero_q, o_zero_d;
  logic              o_uf_q, o_uf_d;

  logic s2_en;
  logic s1_en;
  logic accept;
  logic s2_load;

  // A stage advances when it is empty or the stage after it is advancing.
  assign s2_en   = ~o_valid_q | i_ready;
  assign s1_en   = ~s1_valid_q | s2_en;
  assign o_ready = s1_en;
  assign accept  = i_valid & s1_en;
  assign s2_load = s2_en & s1_valid_q;

  // Classify the incoming beat and pick the effective shift and exponent.
  always_comb begin
    dec_zero_case = i_zero_flag | (int'(i_pos_one) >= MANT_W);
    dec_sh   = CNT_ZERO;
    dec_exp  = EXP_ZERO;
    dec_mant = i_mant;
    dec_zero = 1'b0;
    dec_uf   = 1'b0;
    if (dec_zero_case) begin
      dec_zero = 1'b1;
    end else if (i_exp == EXP_ZERO) begin
      dec_uf = 1'b1;
`ifndef MUL_NORM_DENORM_EN
      dec_mant = MANT_ZERO;
      dec_zero = 1'b1;
`endif
    end else if (int'(i_exp) > int'(i_pos_one)) begin
      dec_sh  = i_pos_one;
      dec_exp = i_exp - EXP_W'(i_pos_one);
    end else begin
      // 1 <= i_exp <= i_pos_one < MANT_W, so i_exp-1 always fits the shift count.
      dec_uf = 1'b1;
`ifdef MUL_NORM_DENORM_EN
      dec_sh = CNT_W'(i_exp - EXP_ONE);
`else
      dec_mant = MANT_ZERO;
      dec_zero = 1'b1;
`endif
    end
  end

  // Stage 1 next state: capture an accepted beat, drain when stage 2 takes it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mant_d  = s1_mant_q;
    s1_sh_d    = s1_sh_q;
    s1_exp_d   = s1_exp_q;
    s1_zero_d  = s1_zero_q;
    s1_uf_d    = s1_uf_q;
    if (s1_en) begin
      s1_valid_d = i_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (accept) begin
      s1_sign_d = i_sign;
      s1_mant_d = dec_mant;
      s1_sh_d   = dec_sh;
      s1_exp_d  = dec_exp;
      s1_zero_d = dec_zero;
      s1_uf_d   = dec_uf;
    end else begin
      s1_sign_d = s1_sign_q;
      s1_mant_d = s1_mant_q;
    end
  end

  // Stage 2 next state: apply the shift and present the result.
  always_comb begin
    o_valid_d = o_valid_q;
    o_sign_d  = o_sign_q;
    o_exp_d   = o_exp_q;
    o_mant_d  = o_mant_q;
    o_zero_d  = o_zero_q;
    o_uf_d    = o_uf_q;
    if (s2_en) begin
      o_valid_d = s1_valid_q;
    end else begin
      o_valid_d = o_valid_q;
    end
    if (s2_load) begin
      o_sign_d = s1_sign_q;
      o_exp_d  = s1_exp_q;
      o_mant_d = s1_mant_q << s1_sh_q;
      o_zero_d = s1_zero_q;
      o_uf_d   = s1_uf_q;
    end else begin
      o_sign_d = o_sign_q;
      o_mant_d = o_mant_q;
    end
  end

  // Pipeline registers; reset discards any in-flight beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mant_q  <= MANT_ZERO;
      s1_sh_q    <= CNT_ZERO;
      s1_exp_q   <= EXP_ZERO;
      s1_zero_q  <= 1'b0;
      s1_uf_q    <= 1'b0;
      o_valid_q  <= 1'b0;
      o_sign_q   <= 1'b0;
      o_exp_q    <= EXP_ZERO;
      o_mant_q   <= MANT_ZERO;
      o_zero_q   <= 1'b0;
      o_uf_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mant_q  <= s1_mant_d;
      s1_sh_q    <= s1_sh_d;
      s1_exp_q   <= s1_exp_d;
      s1_zero_q  <= s1_zero_d;
      s1_uf_q    <= s1_uf_d;
      o_valid_q  <= o_valid_d;
      o_sign_q   <= o_sign_d;
      o_exp_q    <= o_exp_d;
      o_mant_q   <= o_mant_d;
      o_zero_q   <= o_zero_d;
      o_uf_q     <= o_uf_d;
    end
  end

  assign o_valid     = o_valid_q;
  assign o_sign      = o_sign_q;
  assign o_exp       = o_exp_q;
  assign o_mant      = o_mant_q;
  assign o_zero      = o_zero_q;
  assign o_underflow = o_uf_q;

endmodule
